// File: rtl/dmi_pkg.sv
// Shared definitions for the debug-module-interface register target.
// Holds op codes, response codes, the address map, FSM state encodings
// and the captured-request record used by dmi_reg_target and dmi_regbank.
package dmi_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  localparam logic [6:0] ADDR_SCRATCH_LO = 7'h04;
  localparam logic [6:0] ADDR_SCRATCH_HI = 7'h0B;
  localparam logic [6:0] ADDR_ID         = 7'h10;
  localparam logic [6:0] ADDR_STATUS     = 7'h11;
  localparam logic [6:0] ADDR_EXIT       = 7'h3F;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

endpackage

// File: rtl/dmi_reg_target_if.sv
// Request/response handshake bundle between a debug transport (master)
// and the register target (slave).
//   debug_req_*  : request valid/ready, 7-bit address, 2-bit op, 32-bit data
//   debug_resp_* : response valid/ready, 2-bit resp code, 32-bit read data
interface dmi_reg_target_if;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;

  modport master (
    output debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
           debug_req_bits_data, debug_resp_ready,
    input  debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
           debug_resp_bits_data
  );

  modport slave (
    input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
           debug_req_bits_data, debug_resp_ready,
    output debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
           debug_resp_bits_data
  );
endinterface

// File: rtl/dmi_regbank.sv
// Register storage and address decode for the DMI target.
//   clk, reset : clock, synchronous active-high reset
//   we_i       : apply a write this cycle (only lands on writable addresses)
//   op_i       : op of the request being evaluated
//   addr_i     : register address
//   wdata_i    : write data
//   status_i   : accepted-request count to report through STATUS
//   rdata_o    : response data (0 for non-reads and failures)
//   resp_o     : response code for op_i/addr_i
//   exit_o     : EXIT register contents
module dmi_regbank
  import dmi_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [1:0]  op_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] status_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  resp_o,
  output logic [31:0] exit_o
);

  logic [31:0] scratch_q [8];
  logic [31:0] exit_q;
  logic        is_scratch;
  logic        mapped;
  logic        writable;
  logic [2:0]  idx;
  logic [31:0] reg_val;

  assign is_scratch = (addr_i >= ADDR_SCRATCH_LO) && (addr_i <= ADDR_SCRATCH_HI);
  // 0x04..0x0B -> 0..7: low three bits plus 4, modulo 8
  assign idx        = addr_i[2:0] + 3'd4;
  assign writable   = is_scratch || (addr_i == ADDR_EXIT);
  assign mapped     = writable || (addr_i == ADDR_ID) || (addr_i == ADDR_STATUS);

  always_comb begin
    reg_val = 32'h0;
    if (is_scratch)                reg_val = scratch_q[idx];
    else if (addr_i == ADDR_ID)     reg_val = ID_VALUE;
    else if (addr_i == ADDR_STATUS) reg_val = {16'h0, status_i};
    else if (addr_i == ADDR_EXIT)   reg_val = exit_q;
  end

  always_comb begin
    rdata_o = 32'h0;
    resp_o  = RESP_FAIL;
    case (op_i)
      OP_NOP:   resp_o = RESP_OK;
      OP_READ: begin
        if (mapped) begin
          resp_o  = RESP_OK;
          rdata_o = reg_val;
        end
      end
      OP_WRITE: resp_o = writable ? RESP_OK : RESP_FAIL;
      default:  resp_o = RESP_FAIL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) scratch_q[i] <= 32'h0;
      exit_q <= 32'h0;
    end else if (we_i && writable) begin
      if (is_scratch) scratch_q[idx] <= wdata_i;
      else            exit_q         <= wdata_i;
    end
  end

  assign exit_o = exit_q;

endmodule

// File: rtl/dmi_reg_target.sv
// DMI register target: accepts one request at a time, waits LATENCY extra
// cycles, then presents a response until the consumer takes it.
//   clk, reset : clock, synchronous active-high reset
//   dmi        : request/response handshake bundle (slave side)
//   exit       : sticky exit code from the EXIT register
module dmi_reg_target
  import dmi_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h0000_0001,
  parameter int unsigned LATENCY  = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmi_reg_target_if.slave  dmi,
  output logic [31:0]      exit
);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] count_q, count_d;
  dmi_req_t    req_q, bus_req, eval_req;
  logic [1:0]  resp_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        enter_resp;
  logic [31:0] rb_rdata;
  logic [1:0]  rb_resp;
  logic [31:0] rb_exit;

  assign bus_req = '{addr: dmi.debug_req_bits_addr,
                     op:   dmi.debug_req_bits_op,
                     data: dmi.debug_req_bits_data};
  assign accept  = dmi.debug_req_valid && (state_q == ST_IDLE);
  assign count_d = accept ? count_q + 16'd1 : count_q;

  // With LATENCY==0 RESP is entered on the accept edge itself, so the
  // request being evaluated comes straight from the bus in that case.
  assign eval_req = (state_q == ST_IDLE) ? bus_req : req_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: if (dmi.debug_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Side effects happen once, on the edge that enters RESP; STATUS sees the
  // post-accept count so a STATUS read includes itself.
  dmi_regbank #(.ID_VALUE(ID_VALUE)) u_regbank (
    .clk      (clk),
    .reset    (reset),
    .we_i     (enter_resp && (eval_req.op == OP_WRITE)),
    .op_i     (eval_req.op),
    .addr_i   (eval_req.addr),
    .wdata_i  (eval_req.data),
    .status_i (count_d),
    .rdata_o  (rb_rdata),
    .resp_o   (rb_resp),
    .exit_o   (rb_exit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      count_q <= 16'd0;
      req_q   <= '0;
      resp_q  <= RESP_OK;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (accept) req_q <= bus_req;
      if (enter_resp) begin
        resp_q  <= rb_resp;
        rdata_q <= rb_rdata;
      end
    end
  end

  // Outputs are forced low while reset is held, and response bits are
  // zero whenever no response is being presented.
  assign dmi.debug_req_ready      = (state_q == ST_IDLE) && !reset;
  assign dmi.debug_resp_valid     = (state_q == ST_RESP) && !reset;
  assign dmi.debug_resp_bits_resp = dmi.debug_resp_valid ? resp_q : 2'd0;
  assign dmi.debug_resp_bits_data = dmi.debug_resp_valid ? rdata_q : 32'h0;
  assign exit                     = reset ? 32'h0 : rb_exit;

endmodule

// File: tb/tb_dmi_reg_target.sv
module tb_dmi_reg_target;
  import dmi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] exit1, exit0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmi_reg_target_if m1();
  dmi_reg_target_if m0();

  dmi_reg_target #(.ID_VALUE(32'h0000_0001), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .dmi(m1.slave), .exit(exit1)
  );

  dmi_reg_target #(.ID_VALUE(32'h0000_0001), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .dmi(m0.slave), .exit(exit0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=1 target; called at a negedge.
  task automatic txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                     input logic [31:0] wdata, input int hold,
                     input logic [31:0] exp_resp, input logic [31:0] exp_data,
                     output logic [31:0] ex);
    int g;
    int lat;
    logic [1:0]  r0;
    logic [31:0] d0;
    bit stable;
    g = 0;
    while (!m1.debug_req_ready && g < 50) begin @(negedge clk); g++; end
    m1.debug_req_valid     = 1'b1;
    m1.debug_req_bits_op   = op;
    m1.debug_req_bits_addr = addr;
    m1.debug_req_bits_data = wdata;
    @(posedge clk);
    @(negedge clk);
    m1.debug_req_valid     = 1'b0;
    m1.debug_req_bits_op   = OP_NOP;
    m1.debug_req_bits_data = 32'h0;
    lat = 1;
    while (!m1.debug_resp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    r0 = m1.debug_resp_bits_resp;
    d0 = m1.debug_resp_bits_data;
    ex = exit1;
    chk({tag, "_resp"}, {30'h0, r0}, exp_resp);
    chk({tag, "_data"}, d0, exp_data);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (m1.debug_resp_bits_resp !== r0 || m1.debug_resp_bits_data !== d0 ||
          m1.debug_req_ready !== 1'b0 || m1.debug_resp_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, {31'h0, stable}, 32'd1);
    m1.debug_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m1.debug_resp_ready = 1'b0;
    chk({tag, "_rdy_after"}, {31'h0, m1.debug_req_ready}, 32'd1);
  endtask

  logic [31:0] ex;
  int          n;
  int          cyc;
  int          lat0;
  bit          nop_ok;

  initial begin
    m1.debug_req_valid = 1'b0; m1.debug_req_bits_addr = '0; m1.debug_req_bits_op = '0;
    m1.debug_req_bits_data = '0; m1.debug_resp_ready = 1'b0;
    m0.debug_req_valid = 1'b0; m0.debug_req_bits_addr = '0; m0.debug_req_bits_op = '0;
    m0.debug_req_bits_data = '0; m0.debug_resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, m1.debug_req_ready}, 32'd0);
    chk("rst_resp_valid", {31'h0, m1.debug_resp_valid}, 32'd0);
    chk("rst_exit", exit1, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", {31'h0, m1.debug_req_ready}, 32'd1);

    // Scratch write/read, latency 2
    txn("w05", OP_WRITE, 7'h05, 32'hDEADBEEF, 0, 32'd0, 32'h0, ex);
    txn("r05", OP_READ,  7'h05, 32'h0,        0, 32'd0, 32'hDEADBEEF, ex);
    // ID is read-only, unmapped read fails
    txn("r10", OP_READ,  7'h10, 32'h0, 0, 32'd0, 32'h1, ex);
    txn("w10", OP_WRITE, 7'h10, 32'h5, 0, 32'd2, 32'h0, ex);
    txn("r10b", OP_READ, 7'h10, 32'h0, 0, 32'd0, 32'h1, ex);
    txn("r20", OP_READ,  7'h20, 32'h0, 0, 32'd2, 32'h0, ex);
    // EXIT write is visible at RESP entry and sticky
    txn("w3F", OP_WRITE, 7'h3F, 32'h3, 0, 32'd0, 32'h0, ex);
    chk("exit_at_resp", ex, 32'h3);
    txn("nop", OP_NOP,   7'h05, 32'h77, 0, 32'd0, 32'h0, ex);
    chk("exit_after_nop", exit1, 32'h3);
    txn("r05b", OP_READ, 7'h05, 32'h0, 0, 32'd0, 32'hDEADBEEF, ex);
    txn("op3", OP_RSVD,  7'h05, 32'h1111, 0, 32'd2, 32'h0, ex);
    txn("r3F", OP_READ,  7'h3F, 32'h0, 0, 32'd0, 32'h3, ex);
    chk("exit_after_read", exit1, 32'h3);
    // Stalled response stays stable
    txn("w0B", OP_WRITE, 7'h0B, 32'h12345678, 0, 32'd0, 32'h0, ex);
    txn("r0B_hold", OP_READ, 7'h0B, 32'h0, 10, 32'd0, 32'h12345678, ex);
    // 14th accepted request since reset
    txn("status", OP_READ, 7'h11, 32'h0, 0, 32'd0, 32'h0000000E, ex);

    // Reset while waiting drops the write
    m1.debug_req_valid = 1'b1; m1.debug_req_bits_op = OP_WRITE;
    m1.debug_req_bits_addr = 7'h04; m1.debug_req_bits_data = 32'h7;
    @(posedge clk);
    @(negedge clk);
    m1.debug_req_valid = 1'b0; m1.debug_req_bits_op = OP_NOP; m1.debug_req_bits_data = 32'h0;
    chk("wait_ready", {31'h0, m1.debug_req_ready}, 32'd0);
    chk("wait_data_zero", m1.debug_resp_bits_data, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_resp_valid", {31'h0, m1.debug_resp_valid}, 32'd0);
    chk("rst2_req_ready", {31'h0, m1.debug_req_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_ready_after", {31'h0, m1.debug_req_ready}, 32'd1);
    chk("rst2_no_resp", {31'h0, m1.debug_resp_valid}, 32'd0);
    chk("rst2_exit_cleared", exit1, 32'd0);
    txn("status_rst", OP_READ, 7'h11, 32'h0, 0, 32'd0, 32'h1, ex);
    txn("r04_rst", OP_READ, 7'h04, 32'h0, 0, 32'd0, 32'h0, ex);

    // 65537 nops on the LATENCY=0 target, then STATUS wraps to 2
    m0.debug_req_valid = 1'b1; m0.debug_req_bits_op = OP_NOP; m0.debug_resp_ready = 1'b1;
    n = 0; cyc = 0; nop_ok = 1'b1;
    while (n < 65537 && cyc < 200000) begin
      if (m0.debug_req_ready) n++;
      if (m0.debug_resp_valid &&
          (m0.debug_resp_bits_resp !== 2'd0 || m0.debug_resp_bits_data !== 32'h0)) nop_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    m0.debug_req_valid = 1'b0;
    @(negedge clk);
    m0.debug_resp_ready = 1'b0;
    chk("wrap_nops", 32'(n), 32'd65537);
    chk("wrap_nop_resp", {31'h0, nop_ok}, 32'd1);
    m0.debug_req_valid = 1'b1; m0.debug_req_bits_op = OP_READ; m0.debug_req_bits_addr = 7'h11;
    @(posedge clk);
    @(negedge clk);
    m0.debug_req_valid = 1'b0; m0.debug_req_bits_op = OP_NOP;
    lat0 = 1;
    while (!m0.debug_resp_valid && lat0 < 40) begin @(negedge clk); lat0++; end
    chk("wrap_lat", 32'(lat0), 32'd1);
    chk("wrap_resp", {30'h0, m0.debug_resp_bits_resp}, 32'd0);
    chk("wrap_status", m0.debug_resp_bits_data, 32'h2);
    m0.debug_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m0.debug_resp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
